// File: rtl/branch_predictor_bht.sv
// Branch history table plus branch target buffer with run-time selectable prediction modes.
// Define BP_STATS_EN to add saturating branch/mispredict statistics counters.
module branch_predictor_bht #(
    parameter int PC_W    = 32,
    parameter int ENTRIES = 16,
    parameter int IDX_LSB = 2,
    parameter int CNT_W   = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [1:0]      Strategy,
    input  logic            clear,
    input  logic [PC_W-1:0] lk_pc,
    output logic            lk_taken,
    output logic [PC_W-1:0] lk_target,
    input  logic            upd_valid,
    input  logic [PC_W-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [PC_W-1:0] upd_target,
    input  logic            upd_pred,
    output logic            mispredict
`ifdef BP_STATS_EN
    ,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispred
`endif
);

    localparam int IW    = $clog2(ENTRIES);
    localparam int TAG_W = PC_W - IDX_LSB - IW;

    localparam logic [CNT_W-1:0] CNT_SNT = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_WNT = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_WT  = CNT_W'(2);
    localparam logic [CNT_W-1:0] CNT_ST  = CNT_W'(3);

    typedef enum logic [1:0] {
        MODE_NOT_TAKEN = 2'b00,
        MODE_TAKEN     = 2'b01,
        MODE_ONE_BIT   = 2'b10,
        MODE_TWO_BIT   = 2'b11
    } mode_e;

    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [PC_W-1:0]  target_q [ENTRIES];
    logic [CNT_W-1:0] cnt_q    [ENTRIES];

    logic             valid_d  [ENTRIES];
    logic [TAG_W-1:0] tag_d    [ENTRIES];
    logic [PC_W-1:0]  target_d [ENTRIES];
    logic [CNT_W-1:0] cnt_d    [ENTRIES];

    mode_e            mode;
    logic [IW-1:0]    lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_hit;
    logic [IW-1:0]    u_idx;
    logic [TAG_W-1:0] u_tag;
    logic             u_hit;

    // The low PC bits below the index are always zero for word-aligned fetches.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{lk_pc[IDX_LSB-1:0], upd_pc[IDX_LSB-1:0]};

    assign mode   = mode_e'(Strategy);
    assign lk_idx = lk_pc[IDX_LSB +: IW];
    assign lk_tag = lk_pc[PC_W-1 -: TAG_W];
    assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign u_idx  = upd_pc[IDX_LSB +: IW];
    assign u_tag  = upd_pc[PC_W-1 -: TAG_W];
    assign u_hit  = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

    assign mispredict = upd_valid && (upd_pred != upd_taken);

    always_comb begin
        lk_taken  = 1'b0;
        lk_target = lk_hit ? target_q[lk_idx] : '0;
        case (mode)
            MODE_NOT_TAKEN: lk_taken = 1'b0;
            MODE_TAKEN:     lk_taken = lk_hit;
            default:        lk_taken = lk_hit && cnt_q[lk_idx][CNT_W-1];
        endcase
    end

    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        cnt_d    = cnt_q;
        if (clear) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_d[i] = 1'b0;
                cnt_d[i]   = CNT_WNT;
            end
        end else if (upd_valid) begin
            if (upd_taken && !u_hit) begin
                valid_d[u_idx]  = 1'b1;
                tag_d[u_idx]    = u_tag;
                target_d[u_idx] = upd_target;
                cnt_d[u_idx]    = (mode == MODE_ONE_BIT) ? CNT_ST : CNT_WT;
            end else if (upd_taken) begin
                target_d[u_idx] = upd_target;
                if (mode == MODE_ONE_BIT) begin
                    cnt_d[u_idx] = CNT_ST;
                end else if (mode == MODE_TWO_BIT && cnt_q[u_idx] != CNT_ST) begin
                    cnt_d[u_idx] = cnt_q[u_idx] + CNT_W'(1);
                end
            end else if (u_hit) begin
                // A not-taken outcome only trains an existing entry; misses never allocate.
                if (mode == MODE_ONE_BIT) begin
                    cnt_d[u_idx] = CNT_SNT;
                end else if (mode == MODE_TWO_BIT && cnt_q[u_idx] != CNT_SNT) begin
                    cnt_d[u_idx] = cnt_q[u_idx] - CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                cnt_q[i]    <= CNT_WNT;
            end
        end else begin
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            target_q <= target_d;
            cnt_q    <= cnt_d;
        end
    end

`ifdef BP_STATS_EN
    logic [31:0] stat_branches_q, stat_branches_d;
    logic [31:0] stat_mispred_q, stat_mispred_d;

    always_comb begin
        stat_branches_d = stat_branches_q;
        stat_mispred_d  = stat_mispred_q;
        if (clear) begin
            stat_branches_d = '0;
            stat_mispred_d  = '0;
        end else if (upd_valid) begin
            if (stat_branches_q != 32'hFFFF_FFFF) begin
                stat_branches_d = stat_branches_q + 32'd1;
            end
            if (mispredict && stat_mispred_q != 32'hFFFF_FFFF) begin
                stat_mispred_d = stat_mispred_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_branches_q <= '0;
            stat_mispred_q  <= '0;
        end else begin
            stat_branches_q <= stat_branches_d;
            stat_mispred_q  <= stat_mispred_d;
        end
    end

    assign stat_branches = stat_branches_q;
    assign stat_mispred  = stat_mispred_q;
`endif

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Scoreboard testbench for branch_predictor_bht: stimulus queues expected lookup/mispredict
// values, a negedge monitor pops and compares them against the DUT.
module tb_branch_predictor_bht;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  Strategy = 2'b11;
    logic        clear = 1'b0;
    logic [31:0] lk_pc = '0;
    logic        lk_taken;
    logic [31:0] lk_target;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = '0;
    logic        upd_taken = 1'b0;
    logic [31:0] upd_target = '0;
    logic        upd_pred = 1'b0;
    logic        mispredict;
`ifdef BP_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispred;
`endif

    int checks = 0;
    int passes = 0;

    logic        exp_taken_q  [$];
    logic [31:0] exp_target_q [$];
    logic        exp_mis_q    [$];
    string       exp_name_q   [$];

    branch_predictor_bht #(
        .PC_W(32), .ENTRIES(16), .IDX_LSB(2), .CNT_W(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .Strategy(Strategy),
        .clear(clear),
        .lk_pc(lk_pc),
        .lk_taken(lk_taken),
        .lk_target(lk_target),
        .upd_valid(upd_valid),
        .upd_pc(upd_pc),
        .upd_taken(upd_taken),
        .upd_target(upd_target),
        .upd_pred(upd_pred),
        .mispredict(mispredict)
`ifdef BP_STATS_EN
        ,
        .stat_branches(stat_branches),
        .stat_mispred(stat_mispred)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input string field,
                               input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s.%s actual=0x%0h required=0x%0h", name, field, actual, expected);
        end
    endtask

    // Drive one cycle of inputs just after the edge and queue what the lookup should show.
    task automatic applyStimulus(input logic [1:0] s, input logic clr, input logic [31:0] lpc,
                                 input logic uv, input logic [31:0] upc, input logic ut,
                                 input logic [31:0] utgt, input logic up, input string nm,
                                 input logic et, input logic [31:0] etg, input logic em);
        @(posedge clk);
        #1;
        Strategy   = s;
        clear      = clr;
        lk_pc      = lpc;
        upd_valid  = uv;
        upd_pc     = upc;
        upd_taken  = ut;
        upd_target = utgt;
        upd_pred   = up;
        exp_name_q.push_back(nm);
        exp_taken_q.push_back(et);
        exp_target_q.push_back(etg);
        exp_mis_q.push_back(em);
    endtask

    always @(negedge clk) begin
        if (exp_name_q.size() > 0) begin
            string       n;
            logic        et;
            logic [31:0] etg;
            logic        em;
            n   = exp_name_q.pop_front();
            et  = exp_taken_q.pop_front();
            etg = exp_target_q.pop_front();
            em  = exp_mis_q.pop_front();
            checkOutput(n, "lk_taken", {31'd0, lk_taken}, {31'd0, et});
            checkOutput(n, "lk_target", lk_target, etg);
            checkOutput(n, "mispredict", {31'd0, mispredict}, {31'd0, em});
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        applyStimulus(2'b11, 0, 32'h00, 0, 32'h00, 0, 32'h00, 0, "in_reset", 0, 32'h00, 0);
        @(posedge clk);
        #1 reset = 1'b1;

        //            S     clr lk_pc  uv upd_pc ut upd_tgt up  name            taken tgt  mis
        applyStimulus(2'b11, 0, 32'h10, 0, 32'h00, 0, 32'h00, 0, "reset_lookup", 0, 32'h00, 0);
        applyStimulus(2'b11, 0, 32'h10, 1, 32'h10, 1, 32'h1C, 0, "alloc_mis",    0, 32'h00, 1);
        applyStimulus(2'b11, 0, 32'h10, 0, 32'h00, 0, 32'h00, 0, "alloc_hit",    1, 32'h1C, 0);
        applyStimulus(2'b11, 0, 32'h10, 1, 32'h10, 1, 32'h1C, 1, "t2_inc",       1, 32'h1C, 0);
        applyStimulus(2'b11, 0, 32'h10, 1, 32'h10, 0, 32'h00, 1, "n1_dec",       1, 32'h1C, 1);
        applyStimulus(2'b11, 0, 32'h10, 0, 32'h00, 0, 32'h00, 0, "still_taken",  1, 32'h1C, 0);
        applyStimulus(2'b11, 0, 32'h10, 1, 32'h10, 0, 32'h00, 1, "n2_dec",       1, 32'h1C, 1);
        applyStimulus(2'b11, 0, 32'h10, 0, 32'h00, 0, 32'h00, 0, "weak_nt",      0, 32'h1C, 0);
        applyStimulus(2'b11, 0, 32'h10, 1, 32'h10, 0, 32'h00, 0, "n3_to_zero",   0, 32'h1C, 0);
        applyStimulus(2'b11, 0, 32'h10, 1, 32'h10, 1, 32'h1C, 0, "no_underflow", 0, 32'h1C, 1);
        applyStimulus(2'b11, 0, 32'h10, 0, 32'h00, 0, 32'h00, 0, "cnt_is_01",    0, 32'h1C, 0);
        applyStimulus(2'b10, 0, 32'h30, 1, 32'h30, 1, 32'h80, 0, "m10_alloc",    0, 32'h00, 1);
        applyStimulus(2'b10, 0, 32'h30, 1, 32'h30, 0, 32'h00, 1, "m10_taken",    1, 32'h80, 1);
        applyStimulus(2'b10, 0, 32'h30, 0, 32'h00, 0, 32'h00, 0, "m10_flip",     0, 32'h80, 0);
        applyStimulus(2'b01, 0, 32'h30, 0, 32'h00, 0, 32'h00, 0, "m01_hit",      1, 32'h80, 0);
        applyStimulus(2'b00, 0, 32'h30, 0, 32'h00, 0, 32'h00, 0, "m00_never",    0, 32'h80, 0);
        applyStimulus(2'b01, 0, 32'h10, 0, 32'h00, 0, 32'h00, 0, "m01_other",    1, 32'h1C, 0);
        applyStimulus(2'b10, 0, 32'h10, 1, 32'h10, 1, 32'h24, 0, "m10_hit_upd",  0, 32'h1C, 1);
        applyStimulus(2'b11, 0, 32'h10, 0, 32'h00, 0, 32'h00, 0, "mode_switch",  1, 32'h24, 0);
        applyStimulus(2'b11, 0, 32'h10, 1, 32'h50, 1, 32'h60, 0, "alias_alloc",  1, 32'h24, 1);
        applyStimulus(2'b11, 0, 32'h10, 0, 32'h00, 0, 32'h00, 0, "alias_old",    0, 32'h00, 0);
        applyStimulus(2'b11, 0, 32'h50, 0, 32'h00, 0, 32'h00, 0, "alias_new",    1, 32'h60, 0);
        applyStimulus(2'b11, 0, 32'h50, 1, 32'h50, 1, 32'h70, 1, "same_cycle",   1, 32'h60, 0);
        applyStimulus(2'b11, 0, 32'h50, 0, 32'h00, 0, 32'h00, 0, "after_write",  1, 32'h70, 0);
        applyStimulus(2'b11, 0, 32'h90, 1, 32'h90, 0, 32'h00, 0, "nt_miss",      0, 32'h00, 0);
        applyStimulus(2'b11, 0, 32'h50, 0, 32'h00, 0, 32'h00, 0, "nt_no_change", 1, 32'h70, 0);
        applyStimulus(2'b11, 1, 32'h50, 1, 32'h10, 1, 32'h44, 0, "clear_cycle",  1, 32'h70, 1);
        applyStimulus(2'b11, 0, 32'h50, 0, 32'h00, 0, 32'h00, 0, "clear_50",     0, 32'h00, 0);
        applyStimulus(2'b11, 0, 32'h10, 0, 32'h00, 0, 32'h00, 0, "clear_10",     0, 32'h00, 0);
        applyStimulus(2'b11, 0, 32'h30, 1, 32'h30, 1, 32'h88, 0, "realloc",      0, 32'h00, 1);
        applyStimulus(2'b11, 0, 32'h30, 0, 32'h00, 0, 32'h00, 0, "realloc_hit",  1, 32'h88, 0);

        // Reset asserted while an update is in flight must wipe the table and drop that update.
        applyStimulus(2'b11, 0, 32'h30, 1, 32'h30, 1, 32'h99, 0, "mid_reset",    0, 32'h00, 1);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
        reset     = 1'b1;
        upd_valid = 1'b0;
        applyStimulus(2'b11, 0, 32'h30, 0, 32'h00, 0, 32'h00, 0, "post_reset",   0, 32'h00, 0);

`ifdef BP_STATS_EN
        applyStimulus(2'b11, 0, 32'h00, 1, 32'h100, 1, 32'h200, 0, "st1", 0, 32'h00, 1);
        applyStimulus(2'b11, 0, 32'h00, 1, 32'h100, 1, 32'h200, 1, "st2", 0, 32'h00, 0);
        applyStimulus(2'b11, 0, 32'h00, 1, 32'h100, 0, 32'h000, 1, "st3", 0, 32'h00, 1);
        applyStimulus(2'b11, 0, 32'h00, 1, 32'h104, 0, 32'h000, 0, "st4", 0, 32'h00, 0);
        applyStimulus(2'b11, 0, 32'h00, 1, 32'h100, 1, 32'h200, 1, "st5", 0, 32'h00, 0);
        @(posedge clk);
        #1 upd_valid = 1'b0;
        checkOutput("stats", "stat_branches", stat_branches, 32'd5);
        checkOutput("stats", "stat_mispred", stat_mispred, 32'd2);
        upd_valid = 1'b1;
        #1 reset = 1'b0;
        #1;
        checkOutput("stats_reset", "stat_branches", stat_branches, 32'd0);
        checkOutput("stats_reset", "stat_mispred", stat_mispred, 32'd0);
        @(posedge clk);
        #1;
        reset     = 1'b1;
        upd_valid = 1'b0;
`endif

        for (int i = 0; i < 20 && exp_name_q.size() > 0; i++) @(posedge clk);
        if (exp_name_q.size() != 0) begin
            checks++;
            $display("[TB] FAIL drain pending=%0d required=0", exp_name_q.size());
        end
        @(posedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/branch_predictor_bht.md
Name: branch_predictor_bht

Overview:
- Parametrised branch history table plus branch target buffer (BHT/BTB) serving the IF stage of CPU_Pipelined.
- Generalises the fixed 2-bit `Strategy` input into four run-time selectable prediction modes, with a configurable table depth.
- IF issues a lookup each cycle and receives taken/target in the same cycle.
- The ID stage, which resolves branches (BEQ/BNE/BGEZ…), writes back the outcome one update per cycle and receives a mispredict flag for flushing.

Parameters:
- PC_W, 32, program-counter width in bits.
- ENTRIES, 16, table depth; must be a power of two, 2..256.
- IDX_LSB, 2, lowest PC bit used for indexing (word-aligned instructions).
- CNT_W, 2, saturating counter width; fixed at 2, reserved for future use.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low; 0 = reset.
- Strategy  in  2  00 static not-taken, 01 static taken, 10 one-bit, 11 two-bit saturating.
- clear  in  1  synchronous invalidate of all entries.
- lk_pc  in  PC_W  fetch PC to look up.
- lk_taken  out  1  predicted taken (combinational).
- lk_target  out  PC_W  predicted target; valid when lk_taken=1 (combinational).
- upd_valid  in  1  resolved branch in ID this cycle.
- upd_pc  in  PC_W  PC of the resolved branch.
- upd_taken  in  1  actual outcome.
- upd_target  in  PC_W  actual target.
- upd_pred  in  1  prediction that was made for this branch, carried down the pipe.
- mispredict  out  1  upd_valid & (upd_pred != upd_taken) (combinational).

Behaviour:
- IW = log2(ENTRIES). index = pc[IDX_LSB+IW-1:IDX_LSB]; tag = pc[PC_W-1:IDX_LSB+IW].
- Each entry holds: valid, tag, target[PC_W], cnt[1:0].
- Reset (reset=0, asynchronous): all valid=0, cnt=01, tags and targets=0. Outputs are combinational, so with lk_pc/upd_* at 0 both lk_taken and mispredict are 0.
- hit = valid[index] & (tag[index] == lk tag).
- Prediction by Strategy:
  - 00: lk_taken=0.
  - 01: lk_taken=hit.
  - 10 and 11: lk_taken = hit & cnt[1].
  - lk_target = target[index] whenever hit, else 0.
- Update on posedge when upd_valid=1. Let uhit be hit computed on upd_pc.
  - upd_taken=1, miss: allocate (valid=1, tag, target=upd_target). cnt=11 in mode 10; cnt=10 in modes 11/00/01.
  - upd_taken=1, hit: target=upd_target. cnt=11 in mode 10; cnt=sat+1 (max 11) in mode 11; cnt unchanged in 00/01.
  - upd_taken=0, hit: cnt=00 in mode 10; cnt=sat-1 (min 00) in mode 11; unchanged otherwise. Entry stays valid.
  - upd_taken=0, miss: no table change.
- Same-cycle lookup and update to the same index: lookup returns the pre-update contents. Write takes effect at the edge; no bypass.
- clear=1: all valid=0 and cnt=01 at the next edge; overrides a simultaneous update.
- Strategy change mid-run: table is preserved; the new mode interprets the existing cnt from the next lookup.
- Reset asserted mid-operation clears the table immediately; the in-flight update is discarded.
- Alias: a different PC with the same index and tag collision is impossible by construction (full upper-bit tag). The same index with a different tag on a taken update replaces the entry.

Optional Feature:
- Macro BP_STATS_EN.
- Defined: adds outputs stat_branches[31:0] and stat_mispred[31:0].
  - stat_branches increments on every upd_valid.
  - stat_mispred increments when mispredict=1.
  - Both reset to 0 on reset=0 and on clear. They saturate at 32'hFFFFFFFF rather than wrapping.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then lk_pc=0x10 in mode 11 -> lk_taken=0, lk_target=0, mispredict=0.
- Mode 11, update pc=0x10 taken target=0x1C upd_pred=0 -> mispredict=1; next cycle lk_pc=0x10 gives lk_taken=1, lk_target=0x1C (cnt=10).
- Mode 11, pc=0x10 sequence T,T,N -> cnt 10→11→10, prediction still taken; a second N gives cnt=01 and lk_taken=0.
- Mode 10, pc=0x30 taken then not-taken -> lk_taken 1 then 0 (single-miss flip). Mode 01 afterwards -> lk_taken=1 (entry valid); mode 00 -> 0.
- ENTRIES=16: allocate pc=0x10 then taken pc=0x50 (same index, different tag) -> lookup 0x10 misses, 0x50 hits. Simultaneous lookup and update at 0x50 returns the old entry. clear -> both miss.
- BP_STATS_EN: 5 updates with 2 mispredicts -> stat_branches=5, stat_mispred=2; reset low mid-update -> both 0, table invalid.
